// File: rtl/alorium_lfsr_arb_pkg.sv
// rtl/alorium_lfsr_arb_pkg.sv - shared types and constants for the LFSR arbiter
// Contents: FSM state encoding, datapath widths, LFSR reset value.
package alorium_lfsr_arb_pkg;

  localparam int LFSR_W = 8;
  localparam int STEP_W = 4;

  localparam logic [LFSR_W-1:0] LFSR_RESET_VAL = 8'h01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEED = 2'd1,
    ST_STEP = 2'd2,
    ST_RESP = 2'd3
  } arb_state_e;

endpackage

// File: rtl/alorium_rr_pick.sv
// rtl/alorium_rr_pick.sv - combinational round-robin picker
// Ports:
//   req_i   [NREQ-1:0]  request levels
//   ptr_i   [PTR_W-1:0] index with highest priority this round
//   idx_o   [PTR_W-1:0] winning requester index
//   valid_o             at least one request is active
module alorium_rr_pick #(
  parameter int NREQ  = 4,
  parameter int PTR_W = 2
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [PTR_W-1:0] idx_o,
  output logic             valid_o
);

  // Scan from the farthest offset down to offset 0 so the requester closest
  // to ptr_i (in wrap-around order) is the last assignment and wins.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_i[(int'(ptr_i) + i) % NREQ]) begin
        valid_o = 1'b1;
        idx_o   = PTR_W'((int'(ptr_i) + i) % NREQ);
      end
    end
  end

endmodule

// File: rtl/alorium_lfsr_arb.sv
// rtl/alorium_lfsr_arb.sv - shares one LFSR between NREQ requesters
// Ports:
//   clk, reset_n              clock, async active-low reset
//   req [NREQ-1:0]            level requests, held until gnt
//   seed_wr, seed_data [7:0]  reseed pulse and value
//   steps [3:0]               LFSR steps per draw (0 acts as 1)
//   lfsr_data [7:0]           current LFSR value
//   lfsr_enable, lfsr_new_seed, lfsr_seed [7:0]  LFSR controls
//   gnt [NREQ-1:0], rsp_valid, rsp_data [7:0]    one-cycle response
//   busy                      FSM is not idle
module alorium_lfsr_arb
  import alorium_lfsr_arb_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req,
  input  logic              seed_wr,
  input  logic [LFSR_W-1:0] seed_data,
  input  logic [STEP_W-1:0] steps,
  input  logic [LFSR_W-1:0] lfsr_data,
  output logic              lfsr_enable,
  output logic              lfsr_new_seed,
  output logic [LFSR_W-1:0] lfsr_seed,
  output logic [NREQ-1:0]   gnt,
  output logic              rsp_valid,
  output logic [LFSR_W-1:0] rsp_data,
  output logic              busy
);

  localparam int PTR_W = $clog2(NREQ);

  arb_state_e        state_q, state_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [PTR_W-1:0]  win_q, win_d;
  logic [STEP_W-1:0] cnt_q, cnt_d;
  logic              seed_pend_q, seed_pend_d;
  logic [LFSR_W-1:0] seed_q, seed_d;
  logic [LFSR_W-1:0] lfsr_seed_q, lfsr_seed_d;
  logic [LFSR_W-1:0] rsp_data_q, rsp_data_d;
  logic              en_q, en_d;
  logic              ns_q, ns_d;
  logic              vld_q, vld_d;
  logic              busy_q, busy_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;

  logic [PTR_W-1:0]  pick_idx;
  logic              pick_vld;

  alorium_rr_pick #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .idx_o   (pick_idx),
    .valid_o (pick_vld)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    win_d       = win_q;
    cnt_d       = cnt_q;
    seed_pend_d = seed_pend_q;
    seed_d      = seed_q;
    lfsr_seed_d = lfsr_seed_q;
    rsp_data_d  = rsp_data_q;

    case (state_q)
      ST_IDLE: begin
        if (seed_pend_q) begin
          state_d     = ST_SEED;
          lfsr_seed_d = seed_q;
          seed_pend_d = 1'b0;
        end else if (pick_vld) begin
          state_d = ST_STEP;
          win_d   = pick_idx;
          cnt_d   = (steps == '0) ? STEP_W'(1) : steps;
        end
      end
      ST_SEED: state_d = ST_IDLE;
      ST_STEP: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= STEP_W'(1)) state_d = ST_RESP;
      end
      ST_RESP: begin
        state_d    = ST_IDLE;
        rsp_data_d = lfsr_data;
        ptr_d      = (win_q == PTR_W'(NREQ - 1)) ? '0 : win_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    // A new write always wins over the clear above, so a seed written in the
    // same cycle that SEED is entered stays pending for the next pass.
    if (seed_wr) begin
      seed_pend_d = 1'b1;
      seed_d      = seed_data;
    end

    // Strobes are registered decodes of the next state, so they line up
    // exactly with the state they belong to.
    en_d   = (state_d == ST_STEP);
    ns_d   = (state_d == ST_SEED);
    vld_d  = (state_d == ST_RESP);
    busy_d = (state_d != ST_IDLE);
    gnt_d  = vld_d ? (NREQ'(1) << win_d) : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      win_q       <= '0;
      cnt_q       <= '0;
      seed_pend_q <= 1'b0;
      seed_q      <= '0;
      lfsr_seed_q <= '0;
      rsp_data_q  <= '0;
      en_q        <= 1'b0;
      ns_q        <= 1'b0;
      vld_q       <= 1'b0;
      busy_q      <= 1'b0;
      gnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      win_q       <= win_d;
      cnt_q       <= cnt_d;
      seed_pend_q <= seed_pend_d;
      seed_q      <= seed_d;
      lfsr_seed_q <= lfsr_seed_d;
      rsp_data_q  <= rsp_data_d;
      en_q        <= en_d;
      ns_q        <= ns_d;
      vld_q       <= vld_d;
      busy_q      <= busy_d;
      gnt_q       <= gnt_d;
    end
  end

  assign lfsr_enable   = en_q;
  assign lfsr_new_seed = ns_q;
  assign lfsr_seed     = lfsr_seed_q;
  assign gnt           = gnt_q;
  assign rsp_valid     = vld_q;
  assign busy          = busy_q;
  // The LFSR value only settles after the final step edge, so the response
  // cycle forwards it directly; the register keeps it visible afterwards.
  assign rsp_data      = vld_q ? lfsr_data : rsp_data_q;

endmodule

// File: tb/tb_alorium_lfsr_arb.sv
// tb/tb_alorium_lfsr_arb.sv - scoreboard bench for alorium_lfsr_arb
module tb_alorium_lfsr_arb;
  import alorium_lfsr_arb_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] req = '0;
  logic       seed_wr = 1'b0;
  logic [7:0] seed_data = '0;
  logic [3:0] steps = '0;
  logic [7:0] lfsr_data;
  logic       lfsr_enable, lfsr_new_seed, rsp_valid, busy;
  logic [7:0] lfsr_seed, rsp_data;
  logic [3:0] gnt;

  int n_tests = 0;
  int n_fail  = 0;
  int en_cnt  = 0;
  int ns_cnt  = 0;
  logic [7:0] last_seed = '0;
  logic [11:0] sb[$];

  always #5 clk = ~clk;

  alorium_lfsr_arb #(.NREQ(4)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req           (req),
    .seed_wr       (seed_wr),
    .seed_data     (seed_data),
    .steps         (steps),
    .lfsr_data     (lfsr_data),
    .lfsr_enable   (lfsr_enable),
    .lfsr_new_seed (lfsr_new_seed),
    .lfsr_seed     (lfsr_seed),
    .gnt           (gnt),
    .rsp_valid     (rsp_valid),
    .rsp_data      (rsp_data),
    .busy          (busy)
  );

  // Behavioural model of the shared LFSR: shift left, XNOR feedback, all-ones
  // seed replaced by 0x01.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) lfsr_data <= LFSR_RESET_VAL;
    else if (lfsr_new_seed) lfsr_data <= (lfsr_seed == 8'hFF) ? 8'h01 : lfsr_seed;
    else if (lfsr_enable)
      lfsr_data <= {lfsr_data[6:0], ~(lfsr_data[7] ^ lfsr_data[5] ^ lfsr_data[4] ^ lfsr_data[3])};
  end

  always @(negedge clk) begin
    if (reset_n) begin
      if (lfsr_enable) en_cnt <= en_cnt + 1;
      if (lfsr_new_seed) begin
        ns_cnt    <= ns_cnt + 1;
        last_seed <= lfsr_seed;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req = '0; seed_wr = 1'b0; steps = '0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic wait_rsp(output int cyc);
    logic [11:0] e;
    cyc = -1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        cyc = i;
        if (sb.size() == 0) check("unexpected_rsp", 32'd1, 32'd0);
        else begin
          e = sb.pop_front();
          check("gnt", 32'(gnt), 32'(e[11:8]));
          check("rsp_data", 32'(rsp_data), 32'(e[7:0]));
        end
        break;
      end
    end
    if (cyc < 0) check("rsp_timeout", 32'd0, 32'd1);
  endtask

  task automatic draw(input logic [3:0] m, input logic [3:0] st,
                      input logic [7:0] exp_d, input logic [3:0] exp_g);
    int e0, lat, s;
    s = (st == 0) ? 1 : int'(st);
    sb.push_back({exp_g, exp_d});
    @(posedge clk);
    #1 req = m; steps = st;
    e0 = en_cnt;
    wait_rsp(lat);
    req = '0;
    check("latency", 32'(lat), 32'(s + 2));
    check("enable_cycles", 32'(en_cnt - e0), 32'(s));
  endtask

  typedef struct { logic [3:0] st; logic [7:0] d; } draw_t;
  draw_t tbl[3];

  initial begin
    int lat, n0;

    do_reset();
    @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_vld", 32'(rsp_valid), 32'd0);
    check("rst_data", 32'(rsp_data), 32'd0);
    check("rst_seed", 32'(lfsr_seed), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_strobes", 32'({lfsr_enable, lfsr_new_seed}), 32'd0);

    // Single draws from a fresh LFSR, including steps=0.
    tbl[0] = '{4'd1, 8'h03};
    tbl[1] = '{4'd3, 8'h0F};
    tbl[2] = '{4'd0, 8'h03};
    foreach (tbl[k]) begin
      do_reset();
      draw(4'b0001, tbl[k].st, tbl[k].d, 4'b0001);
      @(negedge clk);
      check("rsp_hold", 32'(rsp_data), 32'(tbl[k].d));
      check("idle_vld", 32'(rsp_valid), 32'd0);
    end

    // All requesters held: rotate one grant every 3 cycles.
    do_reset();
    sb.push_back({4'b0001, 8'h03});
    sb.push_back({4'b0010, 8'h07});
    sb.push_back({4'b0100, 8'h0F});
    sb.push_back({4'b1000, 8'h1E});
    sb.push_back({4'b0001, 8'h3D});
    @(posedge clk);
    #1 req = 4'b1111; steps = 4'd1;
    for (int k = 0; k < 5; k++) begin
      wait_rsp(lat);
      check("rr_spacing", 32'(lat), 32'd3);
    end
    req = '0;

    // Two seed writes during a draw: only the last is loaded, once.
    do_reset();
    n0 = ns_cnt;
    sb.push_back({4'b0001, 8'h0F});
    @(posedge clk);
    #1 req = 4'b0001; steps = 4'd3;
    @(posedge clk);
    #1 seed_wr = 1'b1; seed_data = 8'h5A;
    @(posedge clk);
    #1 seed_data = 8'hA5;
    @(posedge clk);
    #1 seed_wr = 1'b0;
    wait_rsp(lat);
    req = '0;
    repeat (5) @(negedge clk);
    check("seed_loads", 32'(ns_cnt - n0), 32'd1);
    check("seed_value", 32'(last_seed), 32'hA5);
    draw(4'b0001, 4'd1, 8'h4B, 4'b0001);

    // All-ones seed passes through unchanged.
    n0 = ns_cnt;
    @(posedge clk);
    #1 seed_wr = 1'b1; seed_data = 8'hFF;
    @(posedge clk);
    #1 seed_wr = 1'b0;
    repeat (3) @(negedge clk);
    check("ff_loads", 32'(ns_cnt - n0), 32'd1);
    check("ff_value", 32'(last_seed), 32'hFF);
    draw(4'b0001, 4'd1, 8'h03, 4'b0001);

    // Reset in the middle of a long draw; ptr was 1 beforehand.
    @(posedge clk);
    #1 req = 4'b0010; steps = 4'd8;
    repeat (4) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("mid_rst_en", 32'(lfsr_enable), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_gnt", 32'({gnt, rsp_valid}), 32'd0);
    check("mid_rst_seed", 32'(lfsr_seed), 32'd0);
    req = '0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    draw(4'b1111, 4'd1, 8'h03, 4'b0001);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
